// File: rtl/la_trigger_sequencer.sv
// Multi-stage trigger sequencer: ordered match stages with occurrence counts; trigger aligned to dout (3-cycle delay).
// Optional macro LA_TRIGGER_EDGE_EN adds per-bit rise/fall terms to each stage match.
module la_trigger_sequencer #(
  parameter  int WIDTH      = 32,
  parameter  int STAGES     = 4,
  parameter  int COUNT_BITS = 16,
  localparam int SW         = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic                         rx_clk,
  input  logic                         rx_rst_n,
  input  logic [WIDTH-1:0]             rx_data,
  input  logic                         arm,
  input  logic                         abort,
  input  logic [SW-1:0]                cfg_last_stage,
  input  logic [STAGES*WIDTH-1:0]      cfg_mask,
  input  logic [STAGES*WIDTH-1:0]      cfg_value,
  input  logic [STAGES*WIDTH-1:0]      cfg_rise,
  input  logic [STAGES*WIDTH-1:0]      cfg_fall,
  input  logic [STAGES*COUNT_BITS-1:0] cfg_count,
  input  logic [STAGES-1:0]            cfg_consecutive,
  output logic [WIDTH-1:0]             dout,
  output logic                         trigger,
  output logic                         active,
  output logic [SW-1:0]                stage
);

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  logic [WIDTH-1:0]    d1_p1_q;
  logic [WIDTH-1:0]    dly_p2_q;
  logic [WIDTH-1:0]    dout_p3_q;
  logic [STAGES-1:0]   m_d, m_p2_q;
  state_t              state_d, state_q;
  logic [SW-1:0]       stage_d, stage_q;
  logic [COUNT_BITS-1:0] count_d, count_q;
  logic                trigger_d, trigger_q;

  logic [SW-1:0]         last_stage;
  logic [COUNT_BITS-1:0] cur_count_cfg;
  logic                  cur_cons;
  logic                  cur_hit;
  logic [COUNT_BITS:0]   cnt_next;
  logic [COUNT_BITS:0]   eff_cnt;

`ifdef LA_TRIGGER_EDGE_EN
  logic [WIDTH-1:0]    d0_p1_q;

  function automatic logic stage_match(input logic [WIDTH-1:0] cur, prev, value, mask, rise, fall);
    logic value_ok, rise_ok, fall_ok;
    value_ok = ((cur ^ value) & mask) == '0;
    rise_ok  = (rise & ~(~prev & cur)) == '0;
    fall_ok  = (fall & ~(prev & ~cur)) == '0;
    return value_ok && rise_ok && fall_ok;
  endfunction
`else
  logic unused_edge_cfg;
  assign unused_edge_cfg = ^{cfg_rise, cfg_fall};

  function automatic logic stage_match(input logic [WIDTH-1:0] cur, value, mask);
    return ((cur ^ value) & mask) == '0;
  endfunction
`endif

  // A programmed count of 0 behaves as 1; widened by one bit so the compare never wraps.
  function automatic logic [COUNT_BITS:0] eff_count(input logic [COUNT_BITS-1:0] c);
    return (c == '0) ? (COUNT_BITS+1)'(1) : {1'b0, c};
  endfunction

  // P2: per-stage match vector from the P1 words
  always_comb begin
    m_d = '0;
    for (int s = 0; s < STAGES; s++) begin
`ifdef LA_TRIGGER_EDGE_EN
      m_d[s] = stage_match(d1_p1_q, d0_p1_q, cfg_value[s*WIDTH +: WIDTH], cfg_mask[s*WIDTH +: WIDTH],
                           cfg_rise[s*WIDTH +: WIDTH], cfg_fall[s*WIDTH +: WIDTH]);
`else
      m_d[s] = stage_match(d1_p1_q, cfg_value[s*WIDTH +: WIDTH], cfg_mask[s*WIDTH +: WIDTH]);
`endif
    end
  end

  // Per-stage config for the current stage, selected without a variable index
  always_comb begin
    cur_count_cfg = '0;
    cur_cons      = 1'b0;
    cur_hit       = 1'b0;
    for (int s = 0; s < STAGES; s++) begin
      if (SW'(s) == stage_q) begin
        cur_count_cfg = cfg_count[s*COUNT_BITS +: COUNT_BITS];
        cur_cons      = cfg_consecutive[s];
        cur_hit       = m_p2_q[s];
      end
    end
  end

  assign last_stage = (cfg_last_stage > SW'(STAGES-1)) ? SW'(STAGES-1) : cfg_last_stage;
  assign cnt_next   = {1'b0, count_q} + (COUNT_BITS+1)'(1);
  assign eff_cnt    = eff_count(cur_count_cfg);

  // P3: sequencing FSM; stage >= last keeps a live config change from stranding the FSM
  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    count_d   = count_q;
    trigger_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d = ST_WAIT;
          stage_d = '0;
          count_d = '0;
        end
      end
      ST_WAIT: begin
        if (arm) begin
          stage_d = '0;
          count_d = '0;
        end else if (cur_hit) begin
          if (cnt_next >= eff_cnt) begin
            count_d = '0;
            if (stage_q >= last_stage) begin
              trigger_d = 1'b1;
              state_d   = ST_IDLE;
              stage_d   = '0;
            end else begin
              stage_d = stage_q + SW'(1);
            end
          end else begin
            count_d = cnt_next[COUNT_BITS-1:0];
          end
        end else if (cur_cons) begin
          count_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d   = ST_IDLE;
      stage_d   = '0;
      count_d   = '0;
      trigger_d = 1'b0;
    end
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
`ifdef LA_TRIGGER_EDGE_EN
      d0_p1_q   <= '0;
`endif
      d1_p1_q   <= '0;
      dly_p2_q  <= '0;
      dout_p3_q <= '0;
      m_p2_q    <= '0;
      state_q   <= ST_IDLE;
      stage_q   <= '0;
      count_q   <= '0;
      trigger_q <= 1'b0;
    end else begin
`ifdef LA_TRIGGER_EDGE_EN
      d0_p1_q   <= d1_p1_q;
`endif
      d1_p1_q   <= rx_data;
      dly_p2_q  <= d1_p1_q;
      dout_p3_q <= dly_p2_q;
      m_p2_q    <= m_d;
      state_q   <= state_d;
      stage_q   <= stage_d;
      count_q   <= count_d;
      trigger_q <= trigger_d;
    end
  end

  assign dout    = dout_p3_q;
  assign trigger = trigger_q;
  assign active  = (state_q == ST_WAIT);
  assign stage   = stage_q;

endmodule

// File: tb/tb_la_trigger_sequencer.sv
// Directed bench for la_trigger_sequencer (default parameters); expectations follow the LA_TRIGGER_EDGE_EN setting.
module tb_la_trigger_sequencer;

  logic         clk;
  logic         rx_rst_n;
  logic [31:0]  rx_data;
  logic         arm;
  logic         abort;
  logic [1:0]   cfg_last_stage;
  logic [127:0] cfg_mask;
  logic [127:0] cfg_value;
  logic [127:0] cfg_rise;
  logic [127:0] cfg_fall;
  logic [63:0]  cfg_count;
  logic [3:0]   cfg_consecutive;
  logic [31:0]  dout;
  logic         trigger;
  logic         active;
  logic [1:0]   stage;

  int checks = 0;
  int errors = 0;

  la_trigger_sequencer #(.WIDTH(32), .STAGES(4), .COUNT_BITS(16)) dut (
    .rx_clk          (clk),
    .rx_rst_n        (rx_rst_n),
    .rx_data         (rx_data),
    .arm             (arm),
    .abort           (abort),
    .cfg_last_stage  (cfg_last_stage),
    .cfg_mask        (cfg_mask),
    .cfg_value       (cfg_value),
    .cfg_rise        (cfg_rise),
    .cfg_fall        (cfg_fall),
    .cfg_count       (cfg_count),
    .cfg_consecutive (cfg_consecutive),
    .dout            (dout),
    .trigger         (trigger),
    .active          (active),
    .stage           (stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [31:0] w, input logic a, input logic ab);
    rx_data = w;
    arm     = a;
    abort   = ab;
    @(posedge clk);
    #1;
    arm   = 1'b0;
    abort = 1'b0;
  endtask

  task automatic clear_cfg();
    cfg_last_stage  = '0;
    cfg_mask        = '0;
    cfg_value       = '0;
    cfg_rise        = '0;
    cfg_fall        = '0;
    cfg_count       = '0;
    cfg_consecutive = '0;
  endtask

  task automatic set_stage(input int s, input logic [31:0] mask, input logic [31:0] value,
                           input logic [31:0] rise, input logic [15:0] cnt, input logic cons);
    cfg_mask[s*32 +: 32]  = mask;
    cfg_value[s*32 +: 32] = value;
    cfg_rise[s*32 +: 32]  = rise;
    cfg_count[s*16 +: 16] = cnt;
    cfg_consecutive[s]    = cons;
  endtask

  task automatic flush();
    drive(32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) drive(32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rx_rst_n = 1'b0;
    rx_data  = 32'hA5A5_1234;
    arm      = 1'b1;
    abort    = 1'b0;
    clear_cfg();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dout !== 32'h0) begin errors++; $display("FAIL reset_dout got %h want 00000000", dout); end
    checks++;
    if ({trigger, active, stage} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got trig=%b act=%b stage=%0d want 0", trigger, active, stage);
    end
    arm      = 1'b0;
    rx_data  = 32'h0;
    rx_rst_n = 1'b1;
    flush();
  endtask

  task automatic test_single_stage();
    logic [31:0] words [10];
    words = '{32'h0, 32'h1111_1111, 32'h2468_ACE0, 32'h0F0F_0F0F, 32'h1234_5678,
              32'hCAFE_F00D, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0};
    clear_cfg();
    set_stage(0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h0, 16'd1, 1'b0);
    flush();
    for (int i = 0; i < 10; i++) begin
      drive(words[i], (i == 0), 1'b0);
      checks++;
      if (trigger !== (i == 8)) begin errors++; $display("FAIL single_trig[%0d] got %b want %b", i, trigger, (i == 8)); end
      checks++;
      if (active !== (i < 8)) begin errors++; $display("FAIL single_active[%0d] got %b want %b", i, active, (i < 8)); end
      if (i == 8) begin
        checks++;
        if (dout !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_dout got %h want deadbeef", dout); end
      end
    end
  endtask

  task automatic test_two_stage();
    logic [31:0] words [8];
    words = '{32'h0, 32'h2, 32'h1, 32'h3, 32'h2, 32'h0, 32'h0, 32'h0};
    clear_cfg();
    set_stage(0, 32'hF, 32'h1, 32'h0, 16'd1, 1'b0);
    set_stage(1, 32'hF, 32'h2, 32'h0, 16'd1, 1'b0);
    cfg_last_stage = 2'd1;
    flush();
    for (int i = 0; i < 8; i++) begin
      drive(words[i], (i == 0), 1'b0);
      checks++;
      if (trigger !== (i == 6)) begin errors++; $display("FAIL two_trig[%0d] got %b want %b", i, trigger, (i == 6)); end
      checks++;
      if (stage !== ((i == 4 || i == 5) ? 2'd1 : 2'd0)) begin
        errors++; $display("FAIL two_stage[%0d] got %0d want %0d", i, stage, (i == 4 || i == 5));
      end
    end
  endtask

  task automatic test_counts();
    logic [31:0] words [16];
    words = '{32'h0, 32'hA5, 32'h00, 32'hA5, 32'h00, 32'hA5, 32'h0, 32'h0,
              32'h0, 32'hA5, 32'hA5, 32'hA5, 32'h0, 32'h0, 32'h0, 32'h0};
    clear_cfg();
    set_stage(0, 32'hFF, 32'hA5, 32'h0, 16'd3, 1'b0);
    flush();
    for (int i = 0; i < 10; i++) begin
      drive(words[i], (i == 0), 1'b0);
      checks++;
      if (trigger !== (i == 7)) begin errors++; $display("FAIL count_loose[%0d] got %b want %b", i, trigger, (i == 7)); end
    end
    cfg_consecutive[0] = 1'b1;
    flush();
    for (int i = 0; i < 16; i++) begin
      drive(words[i], (i == 0), 1'b0);
      checks++;
      if (trigger !== (i == 13)) begin errors++; $display("FAIL count_consec[%0d] got %b want %b", i, trigger, (i == 13)); end
    end
  endtask

  task automatic test_edge();
    logic [31:0] words [9];
    int exp_a;
    int exp_b;
    words = '{32'h0, 32'h1, 32'h1, 32'h0, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0};
`ifdef LA_TRIGGER_EDGE_EN
    exp_a = 6;
    exp_b = 6;
`else
    exp_a = 4;
    exp_b = 2;
`endif
    clear_cfg();
    set_stage(0, 32'h0, 32'h0, 32'h1, 16'd1, 1'b0);
    flush();
    for (int i = 0; i < 9; i++) begin
      drive(words[i], (i == 3), 1'b0);
      checks++;
      if (trigger !== (i == exp_a)) begin errors++; $display("FAIL edge_late_arm[%0d] got %b want %b", i, trigger, (i == exp_a)); end
    end
    cfg_count[15:0] = 16'd2;
    flush();
    for (int i = 0; i < 9; i++) begin
      drive(words[i], (i == 0), 1'b0);
      checks++;
      if (trigger !== (i == exp_b)) begin errors++; $display("FAIL edge_count2[%0d] got %b want %b", i, trigger, (i == exp_b)); end
    end
  endtask

  task automatic test_abort_arm();
    logic [31:0] words [7];
    words = '{32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    clear_cfg();
    set_stage(0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h0, 16'd1, 1'b0);
    flush();
    drive(32'h0, 1'b1, 1'b1);
    checks++;
    if (active !== 1'b0) begin errors++; $display("FAIL abort_arm_same got active=%b want 0", active); end
    drive(32'h0, 1'b0, 1'b0);
    checks++;
    if (active !== 1'b0) begin errors++; $display("FAIL abort_arm_after got active=%b want 0", active); end
    for (int i = 0; i < 7; i++) begin
      drive(words[i], (i == 0), (i == 3));
      checks++;
      if (trigger !== 1'b0) begin errors++; $display("FAIL abort_final_trig[%0d] got %b want 0", i, trigger); end
      checks++;
      if (active !== (i < 3)) begin errors++; $display("FAIL abort_final_active[%0d] got %b want %b", i, active, (i < 3)); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] words [6];
    logic [31:0] rearm [10];
    words = '{32'h0, 32'hA5, 32'h5A, 32'h5A, 32'h0, 32'h0};
    rearm = '{32'hA5, 32'h5A, 32'h5A, 32'h5A, 32'h5A, 32'h5A, 32'h0, 32'h0, 32'h0, 32'h0};
    clear_cfg();
    set_stage(0, 32'hFF, 32'hA5, 32'h0, 16'd1, 1'b0);
    set_stage(1, 32'hFF, 32'h5A, 32'h0, 16'd5, 1'b0);
    cfg_last_stage = 2'd1;
    flush();
    for (int i = 0; i < 6; i++) drive(words[i], (i == 0), 1'b0);
    checks++;
    if (stage !== 2'd1 || active !== 1'b1) begin
      errors++; $display("FAIL mid_pre_reset got stage=%0d act=%b want 1 1", stage, active);
    end
    #2;
    rx_rst_n = 1'b0;
    #1;
    checks++;
    if (dout !== 32'h0) begin errors++; $display("FAIL mid_reset_dout got %h want 00000000", dout); end
    checks++;
    if ({trigger, active, stage} !== 4'b0) begin
      errors++; $display("FAIL mid_reset_ctrl got trig=%b act=%b stage=%0d want 0", trigger, active, stage);
    end
    @(posedge clk);
    #1;
    rx_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive((i[0] ? 32'h5A : 32'hA5), 1'b0, 1'b0);
      checks++;
      if (trigger !== 1'b0 || active !== 1'b0) begin
        errors++; $display("FAIL mid_no_rearm[%0d] got trig=%b act=%b want 0 0", i, trigger, active);
      end
    end
    for (int i = 0; i < 10; i++) begin
      drive(rearm[i], (i == 0), 1'b0);
      checks++;
      if (trigger !== (i == 7)) begin errors++; $display("FAIL mid_rearm_trig[%0d] got %b want %b", i, trigger, (i == 7)); end
    end
  endtask

  initial begin
    test_reset();
    test_single_stage();
    test_two_stage();
    test_counts();
    test_edge();
    test_abort_arm();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/la_trigger_sequencer.md
# la_trigger_sequencer

Multi-stage trigger sequencer in the `rx_clk` domain, directly upstream of the logic analyzer capture engine. It watches each 32-bit sample word and evaluates up to `STAGES` ordered match conditions, each with an occurrence count. When the final stage completes, it emits a one-cycle trigger pulse. The block also forwards a delayed copy of the data so that `trigger` is word-aligned with `dout`; these feed the analyzer's `rx_data` and `rx_trigger` inputs.

## Interface
- `WIDTH`, 32: sample word width.
- `STAGES`, 4: number of sequential match stages (1..8).
- `COUNT_BITS`, 16: width of per-stage occurrence count.

- `rx_clk`  in  1  sample clock; sole clock.
- `rx_rst_n`  in  1  asynchronous, active-low reset.
- `rx_data`  in  `WIDTH`  incoming sample word, one per cycle.
- `arm`  in  1  pulse: restart sequence at stage 0.
- `abort`  in  1  pulse: return to idle without triggering.
- `cfg_last_stage`  in  `$clog2(STAGES)` (min 1)  index of final stage.
- `cfg_mask`  in  `STAGES*WIDTH`  per stage: 1 = bit compared.
- `cfg_value`  in  `STAGES*WIDTH`  per stage: compare value.
- `cfg_rise`  in  `STAGES*WIDTH`  per stage: bit must rise (0→1).
- `cfg_fall`  in  `STAGES*WIDTH`  per stage: bit must fall (1→0).
- `cfg_count`  in  `STAGES*COUNT_BITS`  per stage: matches needed to advance.
- `cfg_consecutive`  in  `STAGES`  per stage: 1 = a non-match clears that stage's count.
- `dout`  out  `WIDTH`  `rx_data` delayed 3 cycles.
- `trigger`  out  1  one-cycle pulse, aligned with the `dout` word that completed the sequence.
- `active`  out  1  sequencer armed and waiting.
- `stage`  out  `$clog2(STAGES)` (min 1)  current stage index.

Stage `s` occupies slice `[s*WIDTH +: WIDTH]` (count: `[s*COUNT_BITS +: COUNT_BITS]`).

## Operation
- Pipeline:
  - P1 registers `rx_data` into `d1` and the previous `d1` into `d0`.
  - P2 registers the per-stage match vector `m[s]`.
  - P3 is the FSM and output register.
- Match condition for stage `s`: `((d1 ^ value) & mask) == 0` AND every `rise` bit has `d0=0, d1=1` AND every `fall` bit has `d0=1, d1=0`.
- FSM states:
  - IDLE: `active=0`, `stage=0`, `count=0`. Move to WAIT on `arm`.
  - WAIT: `active=1`. Each cycle, evaluate `m[stage]`.
    - On match: compute `cnt_next = count+1`. If `cnt_next >= eff_count`, advance: set `stage+1` and `count=0`. If `stage == last`, instead pulse `trigger` and go to IDLE.
    - On match below threshold: `count = cnt_next`.
    - On non-match: if `cfg_consecutive[stage]`, set `count=0`; else hold `count`.
- `eff_count = max(cfg_count[s], 1)`; a value of 0 behaves as 1. Compare at `COUNT_BITS+1` width, so there is no wrap.
- `last = min(cfg_last_stage, STAGES-1)`.
- `arm` while in WAIT restarts the sequence at stage 0 with `count=0`.
- `abort` in any state: go to IDLE with no trigger. `abort` and `arm` asserted in the same cycle: abort wins.
- If the trigger condition and `abort` occur in the same cycle, no trigger is issued.
- Config is read live. Software changes config only while `active=0`; changes while `active=1` give undefined sequencing but must not lock up the FSM.

## Timing
- Reset values: `dout=0`, `trigger=0`, `active=0`, `stage=0`, internal `d0`/`d1`/`m`/`count` all 0.
- Word W sampled at edge N:
  - `m` for W is valid after edge N+1.
  - `trigger` for W is asserted after edge N+2, the same cycle `dout`=W.
- `arm` sampled at edge E: the first word evaluated is the one whose `m` is registered at edge E (visible on `dout` after E+1). That word affects state at edge E+1.
- After a trigger, at most one trigger fires per `arm`. Re-arming is possible the cycle after `trigger`.
- Reset asserted mid-sequence: all state clears immediately (asynchronously). No trigger is issued for in-flight words.
- Edge terms for the first word after reset compare against `d0=0`.

## Configuration
- `LA_TRIGGER_EDGE_EN`:
  - Defined: the rise/fall terms are included in the match, and `d0` is implemented.
  - Undefined: `cfg_rise`/`cfg_fall` ports remain but are ignored, the match is value/mask only, and `d0` is removed. Latency is unchanged.

## Test plan
- Single stage: `last=0`, `mask=FFFFFFFF`, `value=DEADBEEF`, `count=1`. Arm, then feed 5 random words and then DEADBEEF. Required: one `trigger` pulse coincident with `dout=DEADBEEF`, 3 cycles after input; `active` drops on the same edge.
- Two-stage sequence: stage 0 matches `0x1` (`mask 0xF`), stage 1 matches `0x2`. Feed 2,1,3,2. Required: trigger on the final 2 only; `stage` reads 1 after the word 1 is evaluated.
- Counts: `count=3` on stage 0, word pattern A,x,A,x,A. With `consecutive=0`, required trigger on the third A. With `consecutive=1`, no trigger; then A,A,A triggers on the third A.
- Edge, with macro defined: `rise=0x1`, `mask=0`. Feed 0,1,1,0,1. Required: trigger on the second 0→1 only if armed after the first; with `count=2`, trigger on the fifth word. With macro undefined, the same config triggers on the first word.
- Abort/arm priority: `arm` and `abort` asserted together → `active` stays 0. `abort` asserted the same cycle the final match is evaluated → no trigger, IDLE.
- Reset mid-operation: assert `rx_rst_n=0` at stage 1, `count=2`. Required: all outputs 0 immediately; no trigger after release until re-armed.
